mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped serial transmit port downstream of the single-cycle MIPS core's data path.
//  Consumes the core's store traffic: ALU address, rt_out write data and MemWrite/MemRead.
//  Byte stores to TXDATA enter an 8-entry FIFO and are shifted out on a UART line (8N1, LSB first).
//  STATUS reads give software busy/full/empty/overflow state through the read-data mux.
// PARAMETERS
//  BASE_ADDR  32'h0000_0100  TXDATA address; STATUS is at BASE_ADDR+4
//  CLK_DIV    16             clk cycles per serial bit; legal range 2..65535
//  FIFO_AW    3              FIFO address width; depth = 2**FIFO_AW = 8
// PORTS
//  clk       in   1   system clock; all state updates on the rising edge
//  rst       in   1   asynchronous, active-low reset
//  Alu_ans   in   32  byte address from the ALU
//  rt_out    in   32  store data; only [7:0] is used for TXDATA
//  MemWrite  in   1   store strobe; one store per asserted cycle
//  MemRead   in   1   load strobe
//  rd_data   out  32  combinational read data, zero unless a STATUS read hits
//  tx        out  1   serial line, registered; idles high
//  tx_busy   out  1   high when the FSM is not in IDLE
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - FIFO emptied, count=0, overflow=0, FSM=IDLE, tx=1, baud counter=0.
//   - A frame in flight is aborted immediately; tx returns high with no partial stop bit.
//  Decode:
//   - Full 32-bit compare. hit_tx = (Alu_ans==BASE_ADDR); hit_st = (Alu_ans==BASE_ADDR+4).
//   - Other addresses are ignored. rd_data=0 unless MemRead && hit_st.
//  Push:
//   - MemWrite && hit_tx writes rt_out[7:0] at the FIFO write pointer.
//   - Accepted if count < 2**FIFO_AW, or if a pop occurs in the same cycle.
//   - Otherwise the byte is dropped and overflow is set (sticky).
//  STATUS read value:
//   - {24'b0, count[3:0], overflow, full, empty, tx_busy}, with count in bits [7:4].
//  STATUS write:
//   - MemWrite && hit_st && rt_out[3]==1 clears overflow.
//   - If an overflow event hits in the same cycle, set wins.
//  FIFO:
//   - Circular buffer; pointers are FIFO_AW bits and wrap modulo depth; count is FIFO_AW+1 bits.
//   - Simultaneous push and pop leaves count unchanged.
//  FSM states IDLE, START, DATA, STOP; baud counter bcnt counts 0..CLK_DIV-1.
//   - IDLE: tx=1. If FIFO is non-empty: pop into shift[7:0], bcnt=0, go to START.
//   - START: tx=0 for CLK_DIV cycles, then bitn=0 and go to DATA.
//   - DATA: tx=shift[0] for CLK_DIV cycles, then shift>>=1 and bitn++. After bitn==7, go to STOP.
//   - STOP: tx=1 for CLK_DIV cycles. On the last STOP cycle, if the FIFO is non-empty,
//     pop and go straight to START (zero idle gap); otherwise go to IDLE.
//  Latency and frame length:
//   - A push at edge N into an empty FIFO with the FSM in IDLE makes the FIFO non-empty after N.
//   - Pop occurs at edge N+1; tx falls after edge N+1.
//   - Frame length is exactly 10*CLK_DIV cycles.
//  A push never alters the byte currently in the shift register.
//  Push ordering with FIFO full: a push lands in the same cycle as a STOP->START pop;
//   the push is accepted and count stays at depth.
// TESTING (bench uses CLK_DIV=4, BASE_ADDR=32'h100)
//  1. Store 0x55 to 0x100 -> tx low 4 clk, then 1,0,1,0,1,0,1,0 at 4 clk each, then high 4 clk;
//     tx_busy high for 40 clk.
//  2. Store 0xA3, then 0x0F, on consecutive cycles -> two frames with no idle gap (80 clk busy);
//     STATUS then reads 0x3 and FIFO ends empty.
//  3. Store 10 bytes back-to-back while IDLE -> first byte popped, 8 queued, last byte dropped;
//     STATUS reads 0x8D (count=8, overflow, full, busy).
//  4. Store 0x8 to 0x104 -> overflow cleared; same cycle as an overflowing push -> overflow stays set.
//  5. Assert rst=0 during DATA of the 2nd byte -> tx=1 and STATUS=0x2 asynchronously.
//     No further frames after release.
//  6. Read and write 0x108 and 0x0FC -> rd_data=0; FIFO, flags and tx unchanged.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 serial transmitter (LSB first) fed from CPU store traffic.
//
// Stores to BASE_ADDR queue rt_out[7:0] in a circular FIFO of 2**FIFO_AW entries.
// Loads from BASE_ADDR+4 return STATUS:
//   {24'b0, count[3:0], overflow, full, empty, tx_busy}
// Stores to BASE_ADDR+4 with rt_out[3]=1 clear the sticky overflow flag.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   Alu_ans   byte address (full 32-bit decode)
//   rt_out    store data, [7:0] used for TXDATA, [3] used for STATUS writes
//   MemWrite  store strobe
//   MemRead   load strobe
//   rd_data   combinational read data, zero unless a STATUS read hits
//   tx        registered serial line, idles high
//   tx_busy   high whenever the transmit FSM is not in IDLE
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for CLK_DIV cycles
// DATA  | eight data bits, shift[0] on the line, LSB first
// STOP  | stop bit (high); last cycle chains straight into START if more data is queued
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          CLK_DIV   = 16,
  parameter int          FIFO_AW   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Alu_ans,
  input  logic [31:0] rt_out,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        tx_busy
);

  localparam int             DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [15:0]    BCNT_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_nxt;
  logic [15:0]         bcnt, bcnt_nxt;
  logic [2:0]          bitn, bitn_nxt;
  logic [7:0]          shift, shift_nxt;
  logic                tx_nxt;

  logic [7:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    count;
  logic                overflow;

  logic hit_tx, hit_st;
  logic push_req, push_ok, pop;
  logic fifo_empty, fifo_full;
  logic ovf_set, ovf_clr;
  logic bit_done;
  logic [3:0] count_field;

  assign hit_tx     = (Alu_ans == BASE_ADDR);
  assign hit_st     = (Alu_ans == BASE_ADDR + 32'd4);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign bit_done   = (bcnt == BCNT_LAST);

  // A push into a full FIFO still fits when the FSM pops in the same cycle.
  assign push_req = MemWrite && hit_tx;
  assign push_ok  = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && !push_ok;
  assign ovf_clr  = MemWrite && hit_st && rt_out[3];

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    bitn_nxt  = bitn;
    shift_nxt = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          bcnt_nxt  = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) begin
          bcnt_nxt  = '0;
          bitn_nxt  = '0;
          state_nxt = DATA;
        end else begin
          bcnt_nxt = bcnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          bcnt_nxt  = '0;
          shift_nxt = shift >> 1;
          bitn_nxt  = bitn + 3'd1;
          if (bitn == 3'd7) state_nxt = STOP;
        end else begin
          bcnt_nxt = bcnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          bcnt_nxt = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          bcnt_nxt = bcnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // tx is registered from the next state so the line changes on the same edge as the FSM.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      bcnt  <= '0;
      bitn  <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      bitn  <= bitn_nxt;
      shift <= shift_nxt;
      tx    <= tx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Storage needs no reset; the pointers define what is valid. When full, a push and a pop
  // share a slot: the pop reads the old byte combinationally before the edge writes the new one.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rt_out[7:0];
  end

  assign tx_busy     = (state != IDLE);
  assign count_field = 4'(count);
  assign rd_data     = (MemRead && hit_st) ?
                       {24'b0, count_field, overflow, fifo_full, fifo_empty, tx_busy} : 32'b0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: directed scenarios plus randomized store/load traffic,
// checked every cycle against a frame-timeline reference model (byte queue + bit position).
module tb_mmio_uart_tx;

  localparam int          D     = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [31:0] STAT  = 32'h0000_0104;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Alu_ans = '0;
  logic [31:0] rt_out = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] rd_data;
  logic        tx;
  logic        tx_busy;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(D), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst), .Alu_ans(Alu_ans), .rt_out(rt_out),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .rd_data(rd_data), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // reference model: queued bytes, sticky overflow, and the frame in flight by cycle position
  logic [7:0] q[$];
  bit         m_ovf  = 1'b0;
  bit         m_busy = 1'b0;
  int         m_pos  = 0;
  logic [7:0] m_byte = '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] m_status();
    logic [3:0] c;
    c = 4'(q.size());
    return {24'b0, c, m_ovf, (q.size() == DEPTH), (q.size() == 0), m_busy};
  endfunction

  // line level = bit (pos / D) of the 10-bit frame {stop, data[7:0], start}
  function automatic logic m_tx();
    int k;
    if (!m_busy) return 1'b1;
    k = m_pos / D;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[3'(k - 1)];
  endfunction

  task automatic m_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_busy = 1'b0;
    m_pos  = 0;
  endtask

  task automatic m_step(input logic we, input logic [31:0] a, input logic [31:0] d);
    bit         pop;
    bit         ovf_ev;
    logic [7:0] nb;
    nb     = '0;
    ovf_ev = 1'b0;
    pop    = (q.size() != 0) && (!m_busy || m_pos == 10 * D - 1);
    if (pop) nb = q.pop_front();
    if (we && a == BASE) begin
      if (q.size() < DEPTH) q.push_back(d[7:0]);
      else ovf_ev = 1'b1;
    end
    if (ovf_ev) m_ovf = 1'b1;
    else if (we && a == STAT && d[3]) m_ovf = 1'b0;
    if (m_busy) begin
      m_pos++;
      if (m_pos == 10 * D) begin
        if (pop) begin
          m_pos  = 0;
          m_byte = nb;
        end else begin
          m_busy = 1'b0;
        end
      end
    end else if (pop) begin
      m_busy = 1'b1;
      m_pos  = 0;
      m_byte = nb;
    end
  endtask

  // one bus cycle: drive at negedge, check outputs mid-cycle, advance model at posedge
  task automatic cyc(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite = we; MemRead = re; Alu_ans = a; rt_out = d;
    #1;
    check_eq("tx", 32'(tx), 32'(m_tx()));
    check_eq("tx_busy", 32'(tx_busy), 32'(m_busy));
    check_eq("rd_data", rd_data, (re && a == STAT) ? m_status() : 32'h0);
    @(posedge clk);
    m_step(we, a, d);
  endtask

  task automatic idle_rd(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, STAT, 32'h0);
  endtask

  // STATUS read checked against a fixed expected value as well as the model
  task automatic status_is(input string tag, input logic [31:0] exp);
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b1; Alu_ans = STAT; rt_out = '0;
    #1;
    check_eq(tag, rd_data, exp);
    check_eq("status_model", rd_data, m_status());
    @(posedge clk);
    m_step(1'b0, STAT, 32'h0);
  endtask

  initial begin
    // async reset with no clock edge involved
    #1 rst = 1'b0;
    MemRead = 1'b1; Alu_ans = STAT;
    #2;
    check_eq("reset_tx", 32'(tx), 32'h1);
    check_eq("reset_busy", 32'(tx_busy), 32'h0);
    check_eq("reset_status", rd_data, 32'h2);
    @(negedge clk);
    rst = 1'b1;

    // 1: single 0x55 frame
    cyc(1'b1, 1'b0, BASE, 32'h55);
    idle_rd(45);

    // 2: back-to-back bytes, zero idle gap between frames
    cyc(1'b1, 1'b0, BASE, 32'hA3);
    cyc(1'b1, 1'b0, BASE, 32'h0F);
    idle_rd(85);

    // 3: ten stores while idle -> one in flight, eight queued, one dropped
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, BASE, 32'($urandom_range(0, 255)));
    status_is("t3_status", 32'h8D);

    // keep the FIFO full across a STOP->START chain so a push coincides with a pop
    for (int i = 0; i < 45; i++) cyc(1'b1, 1'b0, BASE, 32'($urandom_range(0, 255)));

    // 4: STATUS write without bit 3 keeps overflow; with bit 3 clears it; overflow re-sets
    cyc(1'b1, 1'b0, STAT, 32'h7);
    cyc(1'b0, 1'b1, STAT, 32'h0);
    cyc(1'b1, 1'b0, STAT, 32'h8);
    cyc(1'b0, 1'b1, STAT, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, BASE, 32'($urandom_range(0, 255)));
    idle_rd(420);

    // 5: reset during DATA of the second frame
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, BASE, 32'($urandom_range(0, 255)));
    idle_rd(50);
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b1; Alu_ans = STAT;
    #2 rst = 1'b0;
    #1;
    check_eq("abort_tx", 32'(tx), 32'h1);
    check_eq("abort_status", rd_data, 32'h2);
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_rd(60);

    // 6: neighbouring addresses are ignored, both idle and mid-frame
    cyc(1'b1, 1'b1, 32'h108, 32'hFF);
    cyc(1'b1, 1'b1, 32'h0FC, 32'hFF);
    cyc(1'b1, 1'b0, BASE, 32'h3C);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1, 32'h108, 32'hFFFF_FFFF);
      cyc(1'b1, 1'b1, 32'h0FC, 32'hFFFF_FFFF);
    end
    idle_rd(30);

    // randomized traffic with varying store density
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 700; i++) begin
        logic        we, re;
        logic [31:0] a;
        we = ($urandom_range(0, 7) < 1 + 2 * blk);
        re = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 4))
          0, 1:    a = BASE;
          2:       a = STAT;
          3:       a = 32'h108;
          default: a = $urandom;
        endcase
        cyc(we, re, a, $urandom);
      end
    end
    idle_rd(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
